regbank_mp: RTL

REGBANK_MP -- requirements
Module: regbank_mp

---
 rtl/regbank_pkg.sv | 17 +
 rtl/regbank_scoreboard.sv | 54 +++++
 rtl/regbank_mp.sv | 88 ++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared defaults and helpers for the multi-ported register bank and its scoreboard.
package regbank_pkg;

    localparam int unsigned DefRegWidth  = 32;
    localparam int unsigned DefRegCount  = 16;
    localparam int unsigned DefReadPorts = 2;

    function automatic int unsigned addr_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    localparam int unsigned DefAddrWidth = addr_width(DefRegCount);

    typedef logic [DefReadPorts-1:0][DefAddrWidth-1:0] raddr_arr_t;
    typedef logic [DefReadPorts-1:0][DefRegWidth-1:0]  rdata_arr_t;

endpackage

// File: rtl/regbank_scoreboard.sv
// Busy-bit scoreboard: reservations set a bit, writes clear it, reserve wins on a tie.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int unsigned REG_COUNT  = DefRegCount,
    parameter int unsigned READ_PORTS = DefReadPorts,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned AW         = addr_width(REG_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic                       rsv_en,
    input  logic [AW-1:0]              rsv_addr,
    input  logic [READ_PORTS*AW-1:0]   raddr,
    output logic                       rsv_ok,
    output logic [READ_PORTS-1:0]      rbusy,
    output logic [REG_COUNT-1:0]       busy_vec
);

    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic                 zero_hit;

    assign zero_hit = (ZERO_REG != 0) && (rsv_addr == '0);
    assign rsv_ok   = rsv_en && !busy_q[rsv_addr] && !zero_hit;
    assign busy_vec = busy_q;

    always_comb begin
        for (int unsigned i = 0; i < READ_PORTS; i++) begin
            rbusy[i] = busy_q[raddr[i*AW +: AW]];
        end
    end

    // Set is applied after clear so an accepted reservation survives a same-cycle write.
    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[waddr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regbank_mp.sv
// Multi-read-port register bank with write-first bypass, optional hardwired zero
// register, and a reservation scoreboard.
module regbank_mp
    import regbank_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = DefRegWidth,
    parameter int unsigned REG_COUNT  = DefRegCount,
    parameter int unsigned READ_PORTS = DefReadPorts,
    parameter int unsigned ZERO_REG   = 1,
    localparam int unsigned AW        = addr_width(REG_COUNT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we,
    input  logic [AW-1:0]                   waddr,
    input  logic [REG_WIDTH-1:0]            wdata,
    input  logic [READ_PORTS*AW-1:0]        raddr,
    output logic [READ_PORTS*REG_WIDTH-1:0] rdata,
    output logic [READ_PORTS-1:0]           rbusy,
    input  logic                            rsv_en,
    input  logic [AW-1:0]                   rsv_addr,
    output logic                            rsv_ok,
    output logic [REG_COUNT-1:0]            busy_vec
);

    logic [REG_WIDTH-1:0] regs_q  [REG_COUNT];
    logic [REG_WIDTH-1:0] regs_d  [REG_COUNT];
    logic [REG_WIDTH-1:0] rdata_q [READ_PORTS];
    logic [REG_WIDTH-1:0] rdata_d [READ_PORTS];
    logic                 wr_en;

    assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
    end

    // Reading from the post-write image gives the write-first bypass for free.
    always_comb begin
        for (int unsigned i = 0; i < READ_PORTS; i++) begin
            if ((ZERO_REG != 0) && (raddr[i*AW +: AW] == '0)) begin
                rdata_d[i] = '0;
            end else begin
                rdata_d[i] = regs_d[raddr[i*AW +: AW]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned n = 0; n < REG_COUNT; n++) begin
                regs_q[n] <= '0;
            end
            for (int unsigned i = 0; i < READ_PORTS; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            regs_q  <= regs_d;
            rdata_q <= rdata_d;
        end
    end

    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rdata
        assign rdata[g*REG_WIDTH +: REG_WIDTH] = rdata_q[g];
    end

    regbank_scoreboard #(
        .REG_COUNT  (REG_COUNT),
        .READ_PORTS (READ_PORTS),
        .ZERO_REG   (ZERO_REG),
        .AW         (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .raddr    (raddr),
        .rsv_ok   (rsv_ok),
        .rbusy    (rbusy),
        .busy_vec (busy_vec)
    );

endmodule
